// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU: mult/multu/div/divu
// run one bit per cycle into HI/LO; mfhi/mflo/mthi/mtlo are single-cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [5:0]      Funct,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_sel,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;      // product, or {remainder, dividend/quotient}
  logic [XLEN-1:0] mcand;      // multiplicand magnitude or divisor magnitude
  logic            op_div;
  logic            neg_res;
  logic            neg_rem;
  logic            div0;

  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_mult, is_multu, is_div, is_divu;
  logic is_md, accept, signed_op, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] quo, rem;
  logic [2*XLEN-1:0] prod_fixed;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    is_mfhi  = 1'b0;
    is_mthi  = 1'b0;
    is_mflo  = 1'b0;
    is_mtlo  = 1'b0;
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    if (op_valid) begin
      case (Funct)
        6'b010000: is_mfhi  = 1'b1;
        6'b010001: is_mthi  = 1'b1;
        6'b010010: is_mflo  = 1'b1;
        6'b010011: is_mtlo  = 1'b1;
        6'b011000: is_mult  = 1'b1;
        6'b011001: is_multu = 1'b1;
        6'b011010: is_div   = 1'b1;
        6'b011011: is_divu  = 1'b1;
        default:   ;
      endcase
    end
  end

  assign is_md  = is_mfhi | is_mthi | is_mflo | is_mtlo |
                  is_mult | is_multu | is_div | is_divu;
  assign busy   = (state != IDLE);
  assign stall  = is_md & busy;
  assign accept = is_md & ~busy;

  assign md_sel    = is_mfhi | is_mflo;
  assign md_result = is_mfhi ? hi : (is_mflo ? lo : '0);

  // Operands are reduced to magnitudes at accept; signs are restored in FIX.
  assign signed_op = ~Funct[0];
  assign a_neg     = signed_op & A[XLEN-1];
  assign b_neg     = signed_op & B[XLEN-1];
  assign a_abs     = a_neg ? -A : A;
  assign b_abs     = b_neg ? -B : B;

  // Shift-add: add multiplicand into the upper half when the current LSB is set.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : '0)};

  // Restoring divide: a clear top bit on the trial means the subtract fits.
  assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, mcand};

  assign quo        = acc[XLEN-1:0];
  assign rem        = acc[2*XLEN-1:XLEN];
  assign prod_fixed = neg_res ? -acc : acc;

  // NOTE: all state lives in one clocked block using non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, so a mid-operation reset leaves no residue.
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mthi) hi <= A;
            if (is_mtlo) lo <= A;
            if (is_mult | is_multu) begin
              acc     <= {{XLEN{1'b0}}, b_abs};
              mcand   <= a_abs;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= 1'b0;
              div0    <= 1'b0;
              op_div  <= 1'b0;
              cnt     <= '0;
              state   <= MUL;
            end
            if (is_div | is_divu) begin
              acc     <= {{XLEN{1'b0}}, a_abs};
              mcand   <= b_abs;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              div0    <= (B == '0);
              op_div  <= 1'b1;
              cnt     <= '0;
              state   <= DIV;
            end
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[XLEN-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= FIX;
        end
        DIV: begin
          if (!div_trial[XLEN])
            acc <= {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          else
            acc <= {acc[2*XLEN-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            // Divide by zero: quotient is all ones; remainder sign fix restores raw A.
            lo <= div0 ? '1 : (neg_res ? -quo : quo);
            hi <= neg_rem ? -rem : rem;
          end else begin
            hi <= prod_fixed[2*XLEN-1:XLEN];
            lo <= prod_fixed[XLEN-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU. It consumes the same R-type Funct field and sign convention the ALU control path decodes.
- Executes mult/multu/div/divu into the HI/LO registers over multiple cycles.
- Serves mfhi/mflo/mthi/mtlo.
- Raises a stall request so hazard logic holds the EX instruction while the unit is busy.

Parameters:
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- op_valid  input  1  EX holds a valid R-type instruction (ALUOp[2:0]==3'b010) not being flushed
- Funct  input  6  instruction funct field
- A  input  XLEN  rs operand (forwarded)
- B  input  XLEN  rt operand (forwarded)
- stall  output  1  hold pipeline at EX
- md_result  output  XLEN  mfhi/mflo read data
- md_sel  output  1  EX writeback takes md_result instead of ALU output
- busy  output  1  iteration in progress
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Reset values:
  - state=IDLE
  - hi=0, lo=0
  - busy=0, stall=0
  - md_result=0, md_sel=0
- Decode, active only when op_valid=1:
  - 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - Any other Funct: the unit ignores it.
- Sign rule: signed = ~Funct[0] for mult/div.
- is_md = op_valid & Funct is one of the 8 codes above.
- stall = is_md & (state!=IDLE), combinational.
  - Non-md instructions never stall, even while busy.
- md_sel = op_valid & (mfhi|mflo), combinational.
  - md_result = hi for mfhi, lo for mflo, 0 otherwise.
  - md_result is only meaningful when stall=0.
- States:
  - IDLE: accepts an op when is_md & !stall.
    - mthi: hi<=A at that edge.
    - mtlo: lo<=A at that edge.
    - mult*/div*: latch |A|, |B| (raw values if unsigned), the result-sign flags and the op kind; cnt<=0; go to MUL or DIV.
    - Accepted mult*/div* do not change hi/lo until FIX.
  - MUL: one shift-add step per cycle on a 2*XLEN product; cnt++; after step XLEN-1 go to FIX.
  - DIV: one restoring subtract-shift step per cycle, producing a quotient bit each cycle; cnt++; after step XLEN-1 go to FIX.
  - FIX: write hi/lo, apply sign correction, go to IDLE.
    - Product negated if signs differ.
    - Quotient negated if signs differ; remainder negated if dividend negative.
    - Quotient truncates toward zero.
- busy=1 in MUL, DIV and FIX.
- Latency: op accepted at edge N; hi/lo valid from edge N+XLEN+1 (33 cycles for XLEN=32). busy is high for exactly XLEN+1 cycles.
- Mult: hi=product[2X-1:X], lo=product[X-1:0].
- Div: lo=quotient, hi=remainder.
- Divide by zero (B==0 at accept): result lo=all-ones, hi=A (raw A, no sign fix). Timing is still full latency.
- Signed overflow -2^31 / -1: lo=0x80000000, hi=0.
- Back-to-back ops: a second md op, including mfhi/mflo, stalls until the cycle after FIX. It is accepted in the first IDLE cycle and reads the new hi/lo.
- op_valid dropping mid-iteration (instruction flushed after accept) does not abort; the operation completes. Flushing happens before accept.
- reset mid-operation: returns to IDLE next edge, hi=lo=0, no partial write.

Test Plan:
- multu A=0xFFFFFFFF B=0xFFFFFFFF -> stall high 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- mult A=-3 (0xFFFFFFFD) B=5, then mflo -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; mflo stalls until done, then md_result=0xFFFFFFF1, md_sel=1.
- div A=-7 B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7 B=0 -> lo=0xFFFFFFFF, hi=0x00000007 after 33 cycles.
- div A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0; divu same operands -> lo=0, hi=0x80000000.
- mthi A=0x1234, then mfhi next cycle -> no stall, md_result=0x1234. An ALU add issued while busy -> stall=0.
- Start mult 6*7, assert reset at cycle 10 -> busy=0, hi=lo=0 next cycle. Subsequent multu 6*7 -> lo=42, hi=0.
